// File: rtl/ifu_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: PC width, state codes
// and the sequential next-PC helper used by the PC register and next-PC select.
package ifu_fetch_ctrl_pkg;

    localparam int unsigned PC_W   = 30;
    localparam int unsigned INST_W = 32;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam logic [1:0] BOOT    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] DELIVER = 2'd2;
    localparam logic [1:0] ERROR   = 2'd3;

    // Word-addressed increment; wraps from all-ones back to zero.
    function automatic pc_t pc_incr(input pc_t pc);
        return pc + pc_t'(1);
    endfunction

endpackage

// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bus: instruction memory req/ack, decode valid/ready,
// redirect input and the sticky error flag. master = fetch controller side.
interface ifu_fetch_ctrl_if;
    import ifu_fetch_ctrl_pkg::*;

    logic  imem_req;
    pc_t   imem_addr;
    logic  imem_ack;
    inst_t imem_rdata;
    logic  inst_valid;
    logic  inst_ready;
    inst_t inst;
    pc_t   inst_pc;
    logic  redir_valid;
    pc_t   redir_target;
    logic  fetch_err;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
        input  imem_ack, imem_rdata, inst_ready, redir_valid, redir_target
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc, fetch_err,
        output imem_ack, imem_rdata, inst_ready, redir_valid, redir_target
    );

endinterface

// File: rtl/ifu_fetch_ctrl_redirect_buf.sv
// Pending-redirect buffer: remembers the newest redirect since the last delivery
// and selects the next fetch PC (live redirect > pending redirect > pc+1).
module ifu_redirect_buf
    import ifu_fetch_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic capture_en_i,
    input  logic handshake_i,
    input  logic redir_valid_i,
    input  pc_t  redir_target_i,
    input  pc_t  pc_i,
    output pc_t  next_pc_o
);

    logic pend_valid_q, pend_valid_d;
    pc_t  pend_target_q, pend_target_d;

    always_comb begin
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        // A redirect arriving in the handshake cycle is consumed by the bypass.
        if (handshake_i) begin
            pend_valid_d = 1'b0;
        end else if (capture_en_i && redir_valid_i) begin
            pend_valid_d  = 1'b1;
            pend_target_d = redir_target_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    always_comb begin
        if (redir_valid_i) begin
            next_pc_o = redir_target_i;
        end else if (pend_valid_q) begin
            next_pc_o = pend_target_q;
        end else begin
            next_pc_o = pc_incr(pc_i);
        end
    end

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Stall-aware fetch sequencer: one outstanding imem request, one buffered
// instruction toward decode, single-delay-slot redirects and a fetch timeout.
module ifu_fetch_ctrl
    import ifu_fetch_ctrl_pkg::*;
#(
    parameter pc_t         RESET_PC = 30'h0,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    ifu_fetch_ctrl_if.master bus
);

    logic [1:0]       state_q, state_d;
    pc_t              pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    inst_t            inst_q, inst_d;
    pc_t              inst_pc_q, inst_pc_d;
    logic             err_q, err_d;

    logic handshake;
    logic capture_en;
    pc_t  next_pc;

    assign handshake  = (state_q == DELIVER) && bus.inst_ready;
    assign capture_en = (state_q == FETCH) || (state_q == DELIVER);

    ifu_redirect_buf u_redirect_buf (
        .clk            (clk),
        .rst            (rst),
        .capture_en_i   (capture_en),
        .handshake_i    (handshake),
        .redir_valid_i  (bus.redir_valid),
        .redir_target_i (bus.redir_target),
        .pc_i           (pc_q),
        .next_pc_o      (next_pc)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        err_d     = err_q;
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                cnt_d   = '0;
            end
            FETCH: begin
                if (bus.imem_ack) begin
                    inst_d    = bus.imem_rdata;
                    inst_pc_d = pc_q;
                    cnt_d     = '0;
                    state_d   = DELIVER;
                end else begin
                    // Counter may reach TIMEOUT itself, hence 2^CNT_W > TIMEOUT.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ERROR;
                    end
                end
            end
            DELIVER: begin
                if (bus.inst_ready) begin
                    pc_d    = next_pc;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            default: begin
                err_d   = 1'b1;
                state_d = ERROR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            cnt_q     <= '0;
            inst_q    <= '0;
            inst_pc_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            err_q     <= err_d;
        end
    end

    assign bus.imem_req   = (state_q == FETCH);
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = (state_q == DELIVER);
    assign bus.inst       = inst_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.fetch_err  = err_q;

endmodule
